// File: rtl/sb_pkg.sv
// Sideband framing constants, transmit FSM encoding and the CRC-16 byte update.
package sb_pkg;

  localparam logic [7:0]  DLE      = 8'hFE;
  localparam logic [7:0]  STX_CMD  = 8'h05;
  localparam logic [7:0]  STX_RSP  = 8'h04;
  localparam logic [7:0]  ETX      = 8'h40;
  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int          MAX_LEN  = 64;

  typedef enum logic [3:0] {
    IDLE,
    DLE_H,
    STX,
    PAYLOAD,
    STUFF,
    CRC_L,
    CRC_H,
    DLE_T,
    ETX_S
  } sb_tx_state_t;

  // Which byte a stuffed DLE follows, so STUFF knows where to resume.
  typedef enum logic [1:0] {
    SRC_PAY,
    SRC_CRCL,
    SRC_CRCH
  } sb_stuff_src_t;

  // MSB-first CRC-16 over one byte, no reflection, no final XOR.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_uart_byte_tx.sv
// UART byte serializer (start, d[0]..d[7], stop); start bit appears the cycle after load.
// A load in the stop-bit cycle chains symbols with no gap; when idle the line sits at 1.
module sb_uart_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       bit_last,
  output logic       sbtx
);

  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    if (load) begin
      busy_d = 1'b1;
      cnt_d  = 4'd0;
      sh_d   = {1'b1, data, 1'b0};
    end else if (busy_q) begin
      sh_d = {1'b1, sh_q[9:1]};
      if (cnt_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      sh_q   <= '1;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
    end
  end

  assign busy     = busy_q;
  assign bit_last = busy_q && (cnt_q == 4'd9);
  assign sbtx     = sh_q[0] | ~busy_q;

endmodule

// File: rtl/sb_tx_framer.sv
// Sideband TX framer: DLE/STX, stuffed payload, CRC-16, DLE/ETX as UART symbols; DLE start bit 1 cycle after accept.
// Next payload byte is requested in each symbol's stop-bit cycle; if absent the line idles high and s_ready holds.
module sb_tx_framer
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rsp_type,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       sbtx,
  output logic       busy,
  output logic       frame_done,
  output logic       len_err
);

  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  sb_tx_state_t  state_q, state_d;
  sb_stuff_src_t src_q, src_d;
  logic [7:0]    hold_q, hold_d;
  logic          last_q, last_d;
  logic          rsp_q, rsp_d;
  logic [15:0]   crc_q, crc_d;
  logic [6:0]    cnt_q, cnt_d;

  logic       tx_ld;
  logic [7:0] tx_dat;
  logic       tx_busy;
  logic       tx_last;
  logic       next_byte;
  logic [7:0] stx_byte;

  assign stx_byte = rsp_q ? STX_RSP : STX_CMD;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    hold_d     = hold_q;
    last_d     = last_q;
    rsp_d      = rsp_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    tx_ld      = 1'b0;
    tx_dat     = DLE;
    next_byte  = 1'b0;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    len_err    = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = enable;
        if (enable && s_valid) begin
          hold_d  = s_data;
          last_d  = s_last;
          rsp_d   = rsp_type;
          crc_d   = CRC_INIT;
          cnt_d   = 7'd1;
          tx_ld   = 1'b1;
          tx_dat  = DLE;
          state_d = DLE_H;
        end
      end
      DLE_H: if (tx_last) begin
        tx_ld   = 1'b1;
        tx_dat  = stx_byte;
        crc_d   = crc16_byte(crc_q, stx_byte);
        state_d = STX;
      end
      STX: if (tx_last) begin
        tx_ld   = 1'b1;
        tx_dat  = hold_q;
        crc_d   = crc16_byte(crc_q, hold_q);
        state_d = PAYLOAD;
      end
      PAYLOAD: begin
        // An idle serializer while in PAYLOAD means we are stalled on upstream.
        if (tx_last && hold_q == DLE) begin
          tx_ld   = 1'b1;
          tx_dat  = DLE;
          src_d   = SRC_PAY;
          state_d = STUFF;
        end else if (tx_last || !tx_busy) begin
          next_byte = 1'b1;
        end
      end
      STUFF: if (tx_last) begin
        case (src_q)
          SRC_PAY: next_byte = 1'b1;
          SRC_CRCL: begin
            tx_ld   = 1'b1;
            tx_dat  = crc_q[15:8];
            state_d = CRC_H;
          end
          default: begin
            tx_ld   = 1'b1;
            tx_dat  = DLE;
            state_d = DLE_T;
          end
        endcase
      end
      CRC_L: if (tx_last) begin
        tx_ld = 1'b1;
        if (crc_q[7:0] == DLE) begin
          tx_dat  = DLE;
          src_d   = SRC_CRCL;
          state_d = STUFF;
        end else begin
          tx_dat  = crc_q[15:8];
          state_d = CRC_H;
        end
      end
      CRC_H: if (tx_last) begin
        tx_ld  = 1'b1;
        tx_dat = DLE;
        if (crc_q[15:8] == DLE) begin
          src_d   = SRC_CRCH;
          state_d = STUFF;
        end else begin
          state_d = DLE_T;
        end
      end
      DLE_T: if (tx_last) begin
        tx_ld   = 1'b1;
        tx_dat  = ETX;
        state_d = ETX_S;
      end
      ETX_S: if (tx_last) begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (next_byte) begin
      if (last_q || cnt_q == LEN_MAX) begin
        len_err = !last_q;
        tx_ld   = 1'b1;
        tx_dat  = crc_q[7:0];
        state_d = CRC_L;
      end else begin
        s_ready = 1'b1;
        state_d = PAYLOAD;
        if (s_valid) begin
          hold_d = s_data;
          last_d = s_last;
          cnt_d  = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 7'd1;
          crc_d  = crc16_byte(crc_q, s_data);
          tx_ld  = 1'b1;
          tx_dat = s_data;
        end
      end
    end
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= SRC_PAY;
      hold_q  <= 8'h00;
      last_q  <= 1'b0;
      rsp_q   <= 1'b0;
      crc_q   <= CRC_INIT;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  sb_uart_byte_tx u_uart (
    .clk      (sb_clk),
    .rst      (rst),
    .load     (tx_ld),
    .data     (tx_dat),
    .busy     (tx_busy),
    .bit_last (tx_last),
    .sbtx     (sbtx)
  );

  assign busy = (state_q != IDLE);

endmodule
